alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
Shares the single combinational ALU between two requesters: requester 0 is the main execute path and requester 1 is the branch/address helper. The block round-robin arbitrates, registers the granted operands, drives the ALU for one cycle and captures its result and zero flag. It then holds the response for the owning requester until that requester acknowledges it. It also keeps a saturating count of completed operations for debug.

Parameters:
WIDTH, 32, operand/result width (matches ALU data width)
CTRL_W, 4, ALU control code width
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle when valid
req0_a  in  WIDTH  operand 1
req0_b  in  WIDTH  operand 2
req0_ctrl  in  CTRL_W  ALU control code
req1_valid, req1_ready, req1_a, req1_b, req1_ctrl  same as above, requester 1
rsp0_valid  out  1  result pending for requester 0
rsp0_ack  in  1  requester 0 consumes result
rsp1_valid  out  1  result pending for requester 1
rsp1_ack  in  1  requester 1 consumes result
rsp_result  out  WIDTH  captured ALU result, shared by both responders
rsp_zero  out  1  captured ALU zero flag
alu_in1  out  WIDTH  to ALU InputData1
alu_in2  out  WIDTH  to ALU InputData2
alu_ctrl  out  CTRL_W  to ALU ALU_Control
alu_result  in  WIDTH  from ALU
alu_zero  in  1  from ALU
busy  out  1  high whenever state is not IDLE
op_count  out  CNT_W  completed operations, saturating

Behaviour:
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, grant selection:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not served last (last_grant pointer).
  - reqN_ready is combinational: high only in IDLE and only for the granted requester. Never high in EXEC or RESP.
- IDLE, acceptance: handshake on valid&&ready at a clock edge.
  - Latch a, b, ctrl into operand registers.
  - Record owner and set last_grant = owner.
  - Go to EXEC.
- Operand stability: a requester must hold valid and operands stable until ready. A deasserted valid is simply not considered.
- EXEC, one cycle:
  - alu_in1/alu_in2/alu_ctrl are driven from the operand registers.
  - At the closing edge, capture alu_result -> rsp_result and alu_zero -> rsp_zero.
  - Assert rspN_valid for the owner and go to RESP.
- ALU drive outside EXEC: alu_ctrl = 0 (ALU default, result 0), and alu_in1/alu_in2 hold the last operand registers.
- RESP:
  - rsp_result/rsp_zero are held stable and only the owner's rspN_valid is high.
  - On the owner's rspN_ack: clear rspN_valid, increment op_count (saturate at all-ones), go to IDLE.
  - Ack from the non-owner, or any ack outside RESP, is ignored.
- Control codes: ctrl is passed through unmodified, including undefined codes (ALU returns 0, zero=1). The arbiter does not interpret it.
- Latency: acceptance edge -> rspN_valid high 2 cycles later. Minimum issue interval is 3 cycles per operation: ack edge -> IDLE, next acceptance possible the same cycle IDLE is entered.
- No new request is granted while in RESP. A requester waiting on its own response does not block arbitration after its ack.
- Reset (asynchronous, any state, including mid-EXEC/RESP):
  - State goes to IDLE and any pending response is discarded.
  - rsp0_valid=0, rsp1_valid=0, rsp_result=0, rsp_zero=0.
  - Operand registers = 0, alu_ctrl=0, busy=0, op_count=0.
  - last_grant=1, so requester 0 wins the first tie.

Test Plan:
- Single op: req0 a=5 b=7 ctrl=1 -> req0_ready same cycle; rsp0_valid 2 cycles after accept with rsp_result=12, rsp_zero=0; ack -> IDLE, op_count=1.
- Tie out of reset: both valid, req0 ctrl=2 (9-9), req1 ctrl=6 (0xF0|0x0F) -> req0 first, rsp0 result 0 zero=1. Next grant goes to req1, rsp1 result 0xFF. Then req0 again while both stay valid (strict alternation).
- Response hold: rsp1 pending, rsp1_ack held low 10 cycles while req0_valid is high -> rsp_result stable, req0_ready stays 0, rsp1_ack pulse then req0 accepted.
- Spurious ack: rsp0_ack pulsed while rsp1 pending -> ignored; rsp1_valid stays 1.
- Undefined ctrl=15, and ctrl=9 with a=0xFFFFFFFE b=3 -> results 0 (zero=1) and 1 respectively.
- Reset asserted asynchronously in EXEC -> outputs clear immediately without a clock edge; no rsp_valid afterwards. op_count saturation with CNT_W=2 -> holds 3 after 5 ops.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// Each operation runs accept (IDLE) -> EXEC (drive ALU, capture) -> RESP (hold until owner acks).
module alu_share_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ack,
  output logic              rsp1_valid,
  input  logic              rsp1_ack,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic [WIDTH-1:0]  alu_in1,
  output logic [WIDTH-1:0]  alu_in2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [CTRL_W-1:0] ctrl;
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] vld, ack, gnt_oh, own_oh, rdy, rsp_vld;
  op_t  [1:0] req_op;
  logic       gnt_any, gnt_id;

  assign vld       = {req1_valid, req0_valid};
  assign ack       = {rsp1_ack, rsp0_ack};
  assign req_op[0] = {req0_a, req0_b, req0_ctrl};
  assign req_op[1] = {req1_a, req1_b, req1_ctrl};

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    gnt_any = |vld;
    gnt_id  = (&vld) ? ~last_q : vld[1];
    gnt_oh  = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    own_oh  = owner_q ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    owner_d = owner_q;
    last_d  = last_q;
    res_d   = res_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          op_d    = req_op[gnt_id];
          owner_d = gnt_id;
          last_d  = gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        if (ack[owner_q]) begin
          cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rdy     = {2{state_q == IDLE}} & gnt_oh;
  assign rsp_vld = {2{state_q == RESP}} & own_oh;

  assign req0_ready = rdy[0];
  assign req1_ready = rdy[1];
  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;

  // Operands stay on the ALU inputs; only the control code is gated to the ALU default outside EXEC.
  assign alu_in1  = op_q.a;
  assign alu_in2  = op_q.b;
  assign alu_ctrl = (state_q == EXEC) ? op_q.ctrl : '0;
  assign busy     = (state_q != IDLE);
  assign op_count = cnt_q;

endmodule
